button_step_pulser: RTL and testbench

- Upstream conditioner for the 0–9 up/down counter.
- Turns two raw, bouncing, asynchronous push-buttons (up, down) into clean single-cycle inc/dec pulses.
- Each button input passes through a synchronizer and a debouncer. A press-arbitration FSM then emits one pulse per press, plus optional auto-repeat while a button is held.
- inc/dec connect directly to the counter's inc/dec inputs.

---
 rtl/button_step_pulser_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 56 +++++
 rtl/button_step_pulser.sv | 137 +++++++++++++
 tb/tb_button_step_pulser.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/button_step_pulser_pkg.sv
// Shared definitions for the push-button step pulser: FSM state encoding
// and the counter-width helper used by the top and the debouncer.
package button_step_pulser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_UP_HELD = 2'd1,
      ST_DN_HELD = 2'd2,
      ST_LOCKED  = 2'd3
   } state_t;

   // Bits needed to hold values 0..value-1, never less than one bit.
   function automatic int clog2_w(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if (value > (32'sd1 <<< i)) w = i + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer: the level only
// follows the synchronized input after it has differed for DB_CYCLES edges.
module btn_debounce #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level
);
   import button_step_pulser_pkg::*;

   localparam int            CW       = clog2_w(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          meta_q;
   logic          sync_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          level_q;
   logic          level_d;

   // Synchronizer chain and debounce state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         meta_q  <= raw;
         sync_q  <= meta_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   // Count edges of disagreement; any agreement restarts the qualification.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/button_step_pulser.sv
// Turns two raw push-buttons into clean one-cycle inc/dec pulses with
// optional auto-repeat; simultaneous presses lock out until both release.
module button_step_pulser #(
   parameter int DB_CYCLES   = 1000000,
   parameter int HOLD_CYCLES = 50000000,
   parameter int RPT_CYCLES  = 10000000,
   parameter int REPEAT_EN   = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_up_raw,
   input  logic btn_dn_raw,
   output logic inc,
   output logic dec,
   output logic up_level,
   output logic dn_level
);
   import button_step_pulser_pkg::*;

   localparam int            TMAX      = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
   localparam int            TW        = clog2_w(TMAX);
   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] RPT_LOAD  = TW'(RPT_CYCLES - 1);

   state_t        state_q;
   state_t        state_d;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic          inc_q;
   logic          inc_d;
   logic          dec_q;
   logic          dec_d;
   logic          up_lvl_s;
   logic          dn_lvl_s;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_up_raw),
      .level   (up_lvl_s)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_dn_raw),
      .level   (dn_lvl_s)
   );

   // FSM state, repeat timer and registered pulse outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
      end
   end

   // Press arbitration; a second button during a hold locks both out.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (up_lvl_s && dn_lvl_s) begin
               state_d = ST_LOCKED;
            end else if (up_lvl_s) begin
               inc_d   = 1'b1;
               state_d = ST_UP_HELD;
               timer_d = HOLD_LOAD;
            end else if (dn_lvl_s) begin
               dec_d   = 1'b1;
               state_d = ST_DN_HELD;
               timer_d = HOLD_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_UP_HELD: begin
            if (!up_lvl_s) begin
               state_d = ST_IDLE;
            end else if (dn_lvl_s) begin
               state_d = ST_LOCKED;
            end else if (REPEAT_EN != 0) begin
               if (timer_q == '0) begin
                  inc_d   = 1'b1;
                  timer_d = RPT_LOAD;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end else begin
               timer_d = timer_q;
            end
         end
         ST_DN_HELD: begin
            if (!dn_lvl_s) begin
               state_d = ST_IDLE;
            end else if (up_lvl_s) begin
               state_d = ST_LOCKED;
            end else if (REPEAT_EN != 0) begin
               if (timer_q == '0) begin
                  dec_d   = 1'b1;
                  timer_d = RPT_LOAD;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end else begin
               timer_d = timer_q;
            end
         end
         ST_LOCKED: begin
            if (!up_lvl_s && !dn_lvl_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign inc      = inc_q;
   assign dec      = dec_q;
   assign up_level = up_lvl_s;
   assign dn_level = dn_lvl_s;

endmodule

// File: tb/tb_button_step_pulser.sv
// Directed bench for button_step_pulser with DB=4, HOLD=20, RPT=8; a second
// instance with auto-repeat disabled shares the same stimulus.
module tb_button_step_pulser;

   logic clk;
   logic reset_n;
   logic btn_up_raw;
   logic btn_dn_raw;
   logic inc, dec, up_level, dn_level;
   logic inc_n, dec_n, up_level_n, dn_level_n;

   int checks;
   int errors;
   int cyc;
   int viol;
   logic prev_inc, prev_dec, prev_inc_n, prev_dec_n;
   int inc_q[$];
   int dec_q[$];
   int incn_q[$];

   button_step_pulser #(
      .DB_CYCLES(4), .HOLD_CYCLES(20), .RPT_CYCLES(8), .REPEAT_EN(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_up_raw(btn_up_raw), .btn_dn_raw(btn_dn_raw),
      .inc(inc), .dec(dec), .up_level(up_level), .dn_level(dn_level)
   );

   button_step_pulser #(
      .DB_CYCLES(4), .HOLD_CYCLES(20), .RPT_CYCLES(8), .REPEAT_EN(0)
   ) dut_norpt (
      .clk(clk), .reset_n(reset_n), .btn_up_raw(btn_up_raw), .btn_dn_raw(btn_dn_raw),
      .inc(inc_n), .dec(dec_n), .up_level(up_level_n), .dn_level(dn_level_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge; sample 1 time unit later and log pulse events by edge number.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (inc) inc_q.push_back(cyc);
      if (dec) dec_q.push_back(cyc);
      if (inc_n) incn_q.push_back(cyc);
      if ((inc && dec) || (inc_n && dec_n)) viol++;
      if ((inc && prev_inc) || (dec && prev_dec)) viol++;
      if ((inc_n && prev_inc_n) || (dec_n && prev_dec_n)) viol++;
      prev_inc = inc; prev_dec = dec; prev_inc_n = inc_n; prev_dec_n = dec_n;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_logs();
      inc_q.delete();
      dec_q.delete();
      incn_q.delete();
   endtask

   function automatic int q_at(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   initial begin
      int k0;
      int exp_off[6];
      exp_off = '{0, 20, 28, 36, 44, 52};
      checks = 0; errors = 0; cyc = 0; viol = 0;
      prev_inc = 1'b0; prev_dec = 1'b0; prev_inc_n = 1'b0; prev_dec_n = 1'b0;
      reset_n = 1'b0; btn_up_raw = 1'b0; btn_dn_raw = 1'b0;
      ticks(2);
      check_eq("rst_inc", inc, 0);
      check_eq("rst_dec", dec, 0);
      check_eq("rst_up_level", up_level, 0);
      check_eq("rst_dn_level", dn_level, 0);
      reset_n = 1'b1;
      ticks(3);

      // 1: clean press held 10 cycles
      clear_logs();
      btn_up_raw = 1'b1;
      tick(); k0 = cyc;
      ticks(4);
      check_eq("s1_level_k4", up_level, 0);
      tick();
      check_eq("s1_level_k5", up_level, 1);
      check_eq("s1_inc_k5", inc, 0);
      tick();
      check_eq("s1_inc_k6", inc, 1);
      tick();
      check_eq("s1_inc_k7", inc, 0);
      ticks(2);
      btn_up_raw = 1'b0;
      ticks(12);
      check_eq("s1_inc_count", inc_q.size(), 1);
      check_eq("s1_inc_edge", q_at(inc_q, 0), k0 + 6);
      check_eq("s1_dec_count", dec_q.size(), 0);
      check_eq("s1_level_released", up_level, 0);

      // 2: bouncing down button
      clear_logs();
      btn_dn_raw = 1'b1; tick();
      btn_dn_raw = 1'b0; tick();
      btn_dn_raw = 1'b1; tick();
      btn_dn_raw = 1'b0; tick();
      btn_dn_raw = 1'b1; tick(); k0 = cyc;
      ticks(12);
      check_eq("s2_dn_level_held", dn_level, 1);
      btn_dn_raw = 1'b0;
      ticks(12);
      check_eq("s2_dec_count", dec_q.size(), 1);
      check_eq("s2_dec_edge", q_at(dec_q, 0), k0 + 6);
      check_eq("s2_inc_count", inc_q.size(), 0);

      // 3: auto-repeat while held 60 cycles
      clear_logs();
      btn_up_raw = 1'b1;
      tick(); k0 = cyc;
      ticks(59);
      btn_up_raw = 1'b0;
      ticks(20);
      check_eq("s3_inc_count", inc_q.size(), 6);
      for (int i = 0; i < 6; i++)
         check_eq($sformatf("s3_rpt%0d", i), q_at(inc_q, i), k0 + 6 + exp_off[i]);
      check_eq("s3_norpt_count", incn_q.size(), 1);
      check_eq("s3_norpt_edge", q_at(incn_q, 0), k0 + 6);
      check_eq("s3_dec_count", dec_q.size(), 0);

      // 4: simultaneous press locks, then a fresh up press works
      clear_logs();
      btn_up_raw = 1'b1; btn_dn_raw = 1'b1;
      ticks(15);
      check_eq("s4_both_levels", {30'd0, up_level, dn_level}, 3);
      btn_up_raw = 1'b0; btn_dn_raw = 1'b0;
      ticks(12);
      check_eq("s4_locked_pulses", inc_q.size() + dec_q.size(), 0);
      btn_up_raw = 1'b1;
      tick(); k0 = cyc;
      ticks(9);
      btn_up_raw = 1'b0;
      ticks(12);
      check_eq("s4_after_inc_count", inc_q.size(), 1);
      check_eq("s4_after_inc_edge", q_at(inc_q, 0), k0 + 6);

      // 5: second button during hold
      clear_logs();
      btn_up_raw = 1'b1;
      tick(); k0 = cyc;
      ticks(8);
      btn_dn_raw = 1'b1;
      ticks(31);
      btn_up_raw = 1'b0;
      ticks(10);
      btn_dn_raw = 1'b0;
      ticks(12);
      check_eq("s5_inc_count", inc_q.size(), 1);
      check_eq("s5_inc_edge", q_at(inc_q, 0), k0 + 6);
      check_eq("s5_dec_count", dec_q.size(), 0);

      // 6: reset mid-hold, button still held afterwards
      clear_logs();
      btn_up_raw = 1'b1;
      tick(); k0 = cyc;
      ticks(16);
      check_eq("s6_first_inc", q_at(inc_q, 0), k0 + 6);
      check_eq("s6_level_before", up_level, 1);
      reset_n = 1'b0;
      #1;
      check_eq("s6_rst_up_level", up_level, 0);
      check_eq("s6_rst_outputs", {28'd0, inc, dec, dn_level, up_level_n}, 0);
      ticks(3);
      clear_logs();
      reset_n = 1'b1;
      tick(); k0 = cyc;
      ticks(8);
      check_eq("s6_reinc_count", inc_q.size(), 1);
      check_eq("s6_reinc_edge", q_at(inc_q, 0), k0 + 6);
      btn_up_raw = 1'b0;
      ticks(12);

      check_eq("pulse_rule_violations", viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
